// File: rtl/hilo_div_ctrl_if.sv
// Bundle between the EX stage, the HI/LO sequencer and the restoring divider.
// The sequencer takes the slave view; the EX stage / divider side takes master.
interface hilo_div_ctrl_if;
    // EX-stage request side
    logic        req;
    logic [5:0]  funct;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        stall;
    logic [31:0] rd_data;

    // Architectural HI/LO state and divide-by-zero flag
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    // Divider side
    logic        div_reset;
    logic [5:0]  div_signal;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_result;

    modport slave (
        input  req, funct, opA, opB, div_result,
        output stall, rd_data, hi, lo, div_zero,
               div_reset, div_signal, div_a, div_b
    );

    modport master (
        output req, funct, opA, opB, div_result,
        input  stall, rd_data, hi, lo, div_zero,
               div_reset, div_signal, div_a, div_b
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and sequencer for the restoring divider.
// A DIVU holds the divider in DIVU for ITER cycles, pulses OUT for one cycle,
// then captures {remainder, quotient} into HI/LO while stalling EX throughout.
module hilo_div_ctrl #(
    parameter int unsigned ITER   = 33,
    parameter logic [5:0]  F_DIVU = 6'b011011,
    parameter logic [5:0]  F_OUT  = 6'b111111
) (
    input  logic            clk,
    input  logic            reset,
    hilo_div_ctrl_if.slave  bus
);

    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_IDLE = 6'b000000;

    localparam int unsigned CW = (ITER > 2) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        XFER,
        CAPT
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [CW-1:0] count;
    logic [5:0]    nextSignal;
    logic [5:0]    divSignal;
    logic [31:0]   hiReg;
    logic [31:0]   loReg;
    logic [31:0]   divA;
    logic [31:0]   divB;
    logic          divZero;
    logic          idleReq;
    logic          acceptDivu;

    // Requests are only honoured in IDLE; everything else is held off by stall.
    assign idleReq    = bus.req && (state == IDLE);
    assign acceptDivu = idleReq && (bus.funct == F_DIVU);

    // Next state and the divider code that goes with that state.
    always_comb begin
        nextState  = state;
        nextSignal = F_IDLE;
        case (state)
            IDLE: begin
                if (acceptDivu) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    nextState = XFER;
                end
            end
            XFER: nextState = CAPT;
            CAPT: nextState = IDLE;
            default: nextState = IDLE;
        endcase
        case (nextState)
            RUN:     nextSignal = F_DIVU;
            XFER:    nextSignal = F_OUT;
            default: nextSignal = F_IDLE;
        endcase
    end

    // State, iteration counter and a registered div_signal so it never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            divSignal <= F_IDLE;
        end else begin
            state     <= nextState;
            divSignal <= nextSignal;
            if (state == RUN) begin
                count <= count + 1'b1;
            end else begin
                count <= '0;
            end
        end
    end

    // Operand latch and sticky divide-by-zero flag, updated only on an accepted DIVU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divA    <= '0;
            divB    <= '0;
            divZero <= 1'b0;
        end else if (acceptDivu) begin
            divA    <= bus.opA;
            divB    <= bus.opB;
            divZero <= (bus.opB == 32'd0);
        end
    end

    // HI/LO: moves from EX while idle, divider result on the capture cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (state == CAPT) begin
            hiReg <= bus.div_result[63:32];
            loReg <= bus.div_result[31:0];
        end else if (idleReq && (bus.funct == F_MTHI)) begin
            hiReg <= bus.opA;
        end else if (idleReq && (bus.funct == F_MTLO)) begin
            loReg <= bus.opA;
        end
    end

    // Combinational read port for MFHI/MFLO.
    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.funct == F_MFHI) begin
            bus.rd_data = hiReg;
        end else if (bus.funct == F_MFLO) begin
            bus.rd_data = loReg;
        end
    end

    assign bus.div_reset  = ~reset;
    assign bus.div_signal = divSignal;
    assign bus.div_a      = divA;
    assign bus.div_b      = divB;
    assign bus.div_zero   = divZero;
    assign bus.hi         = hiReg;
    assign bus.lo         = loReg;
    assign bus.stall      = (state != IDLE);

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Testbench for hilo_div_ctrl: a behavioural restoring-divider stand-in, a
// scoreboard of expected divide results and a monitor that checks each divide
// as stall drops, plus directed and randomised EX-stage stimulus.
module tb_hilo_div_ctrl;

    localparam int         ITER   = 33;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_OUT  = 6'b111111;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_NOP  = 6'b000000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    hilo_div_ctrl_if bus();

    hilo_div_ctrl #(
        .ITER   (ITER),
        .F_DIVU (F_DIVU),
        .F_OUT  (F_OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mHi    = '0;
    logic [31:0] mLo    = '0;
    logic        mZero  = 1'b0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Stand-in divider: loads its output register when it sees OUT.
    always @(posedge clk or posedge bus.div_reset) begin
        if (bus.div_reset) begin
            bus.div_result <= '0;
        end else if (bus.div_signal == F_OUT) begin
            if (bus.div_b == 32'd0) begin
                bus.div_result <= {bus.div_a, 32'hFFFF_FFFF};
            end else begin
                bus.div_result <= {bus.div_a % bus.div_b, bus.div_a / bus.div_b};
            end
        end
    end

    // Monitor: profile each stall window and score it when stall falls.
    int   stallCycles = 0;
    int   divuCycles  = 0;
    int   outCycles   = 0;
    int   zeroCycles  = 0;
    int   badCycles   = 0;
    logic prevStall   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prevStall = 1'b0;
        end else begin
            if (bus.stall && !prevStall) begin
                stallCycles = 0;
                divuCycles  = 0;
                outCycles   = 0;
                zeroCycles  = 0;
                badCycles   = 0;
            end
            if (bus.stall) begin
                stallCycles++;
                if (bus.div_signal == F_DIVU)      divuCycles++;
                else if (bus.div_signal == F_OUT)  outCycles++;
                else if (bus.div_signal == F_NOP)  zeroCycles++;
                else                               badCycles++;
            end
            if (!bus.stall && prevStall) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_divide actual=stall_window required=none");
                end else begin
                    e = expQ.pop_front();
                    checkVal("div_hi",       bus.hi,       e.hi);
                    checkVal("div_lo",       bus.lo,       e.lo);
                    checkVal("div_zero",     bus.div_zero, e.zero);
                    checkVal("div_a_stable", bus.div_a,    e.a);
                    checkVal("div_b_stable", bus.div_b,    e.b);
                    checkVal("stall_cycles", 64'(stallCycles), 64'(ITER + 2));
                    checkVal("divu_cycles",  64'(divuCycles),  64'(ITER));
                    checkVal("out_cycles",   64'(outCycles),   64'd1);
                    checkVal("capt_cycles",  64'(zeroCycles),  64'd1);
                    checkVal("bad_signal",   64'(badCycles),   64'd0);
                end
            end
            prevStall = bus.stall;
        end
    end

    // Present one request for a cycle and update the model if it is accepted.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.funct = f;
        bus.opA   = a;
        bus.opB   = b;
        if (!bus.stall) begin
            if (f == F_DIVU) begin
                e.a    = a;
                e.b    = b;
                e.zero = (b == 32'd0);
                e.hi   = (b == 32'd0) ? a : a % b;
                e.lo   = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
                expQ.push_back(e);
                mHi   = e.hi;
                mLo   = e.lo;
                mZero = e.zero;
            end else if (f == F_MTHI) begin
                mHi = a;
            end else if (f == F_MTLO) begin
                mLo = a;
            end
        end
        @(posedge clk);
        #1;
        bus.req   = 1'b0;
        bus.funct = F_NOP;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (bus.stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.stall) begin
            checks++;
            errors++;
            $display("[TB] FAIL divide_timeout actual=stall_high required=stall_low");
        end
        @(negedge clk);
    endtask

    // Idle-state check of HI/LO through the read port and the direct outputs.
    task automatic checkOutput();
        @(negedge clk);
        bus.funct = F_MFHI;
        #1 checkVal("mfhi", bus.rd_data, mHi);
        bus.funct = F_MFLO;
        #1 checkVal("mflo", bus.rd_data, mLo);
        bus.funct = F_NOP;
        #1 checkVal("rd_nop", bus.rd_data, 32'd0);
        checkVal("hi",         bus.hi,         mHi);
        checkVal("lo",         bus.lo,         mLo);
        checkVal("zero_flag",  bus.div_zero,   mZero);
        checkVal("idle_stall", bus.stall,      1'b0);
        checkVal("idle_sig",   bus.div_signal, F_NOP);
    endtask

    task automatic doDivide(input logic [31:0] a, input logic [31:0] b);
        applyStimulus(F_DIVU, a, b);
        checkVal("stall_rise", bus.stall, 1'b1);
        waitIdle();
        checkOutput();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req   = 1'b0;
        bus.funct = F_NOP;
        bus.opA   = '0;
        bus.opB   = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_div_reset", bus.div_reset,  1'b1);
        checkVal("rst_stall",     bus.stall,      1'b0);
        checkVal("rst_hi",        bus.hi,         32'd0);
        checkVal("rst_lo",        bus.lo,         32'd0);
        checkVal("rst_sig",       bus.div_signal, F_NOP);
        checkVal("rst_zero",      bus.div_zero,   1'b0);
        checkVal("rst_div_a",     bus.div_a,      32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 checkVal("run_div_reset", bus.div_reset, 1'b0);
        checkOutput();

        // Basic divides and the divide-by-zero convention
        doDivide(32'd100, 32'd7);
        doDivide(32'hFFFF_FFFF, 32'd1);
        doDivide(32'd5, 32'd9);
        doDivide(32'h1234, 32'd0);
        doDivide(32'd10, 32'd3);

        // Moves never stall
        applyStimulus(F_MTHI, 32'hA5A5_A5A5, 32'd0);
        checkVal("mthi_stall", bus.stall, 1'b0);
        applyStimulus(F_MTLO, 32'h5A5A_5A5A, 32'd0);
        checkVal("mtlo_stall", bus.stall, 1'b0);
        checkOutput();

        // Requests during a divide are ignored
        applyStimulus(F_DIVU, 32'd1000, 32'd10);
        repeat (9) @(negedge clk);
        applyStimulus(F_MTLO, 32'hDEAD, 32'd0);
        applyStimulus(F_DIVU, 32'd1, 32'd1);
        checkVal("busy_stall", bus.stall, 1'b1);
        waitIdle();
        checkOutput();

        // Reset in the middle of a divide aborts it
        applyStimulus(F_MTHI, 32'h1111_2222, 32'd0);
        applyStimulus(F_DIVU, 32'd77, 32'd0);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("abort_stall",     bus.stall,      1'b0);
        checkVal("abort_hi",        bus.hi,         32'd0);
        checkVal("abort_lo",        bus.lo,         32'd0);
        checkVal("abort_sig",       bus.div_signal, F_NOP);
        checkVal("abort_div_reset", bus.div_reset,  1'b1);
        checkVal("abort_zero",      bus.div_zero,   1'b0);
        expQ.delete();
        mHi   = '0;
        mLo   = '0;
        mZero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        doDivide(32'd9, 32'd2);

        // Randomised mix of operations
        for (int i = 0; i < 30; i++) begin
            int unsigned r;
            logic [31:0] a;
            logic [31:0] b;
            r = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom_range(0, 1) ? 32'($urandom_range(1, 20)) : $urandom;
            if (r == 0) b = 32'd0;
            if (r <= 3) begin
                doDivide(a, b);
            end else if (r == 4) begin
                applyStimulus(F_MTHI, a, b);
                checkOutput();
            end else if (r == 5) begin
                applyStimulus(F_MTLO, a, b);
                checkOutput();
            end else begin
                applyStimulus((r == 6) ? F_MFHI : (r == 7) ? F_MFLO : 6'b101010, a, b);
                checkOutput();
            end
        end

        checkVal("queue_empty", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Sequencer and HI/LO register file directly upstream of the restoring divider.
- Accepts DIVU, MTHI, MTLO, MFHI and MFLO requests from the EX stage.
- Latches the divider operands and drives the divider's 6-bit Signal: DIVU for ITER cycles, then OUT for one cycle.
- Captures the divider's 64-bit {remainder, quotient} result into HI/LO and stalls the pipeline while a divide is in flight.

Parameters:
ITER, 33, number of consecutive cycles div_signal holds DIVU (33 iterations give a 32-bit quotient).
F_DIVU, 6'b011011, funct code for divide-unsigned; also the DIVU value driven on div_signal.
F_OUT, 6'b111111, divider result-transfer code driven on div_signal.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  1  request valid from EX.
funct  input  6  function code: 011011 DIVU, 010001 MTHI, 010011 MTLO, 010000 MFHI, 010010 MFLO; other codes are no-op.
opA  input  32  dividend for DIVU; write data for MTHI/MTLO.
opB  input  32  divisor for DIVU.
div_reset  output  1  active-high reset to the divider; equals ~reset, combinational.
div_signal  output  6  Signal to the divider.
div_a  output  32  latched dividend to the divider.
div_b  output  32  latched divisor to the divider.
div_result  input  64  divider dataOut; [63:32] remainder, [31:0] quotient.
stall  output  1  high while state is not IDLE.
rd_data  output  32  read data: HI for MFHI, LO for MFLO, otherwise 0; combinational.
hi  output  32  HI register.
lo  output  32  LO register.
div_zero  output  1  sticky flag: last accepted DIVU had opB==0.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, count=0.
  - hi, lo, div_a, div_b = 0.
  - div_signal=6'b000000, div_zero=0, stall=0.
  - Reset asserted mid-divide aborts immediately; HI/LO are not updated.
  - div_reset is asserted for the whole reset time, which clears the divider's internal state.
- States: IDLE, RUN, XFER, CAPT.
- IDLE:
  - div_signal=000000.
  - At the edge where req=1 and funct=DIVU: latch div_a=opA, div_b=opB; div_zero=(opB==0); count=0; go to RUN.
  - req with MTHI: hi<=opA. req with MTLO: lo<=opA. State stays IDLE.
- RUN:
  - div_signal=F_DIVU; count increments each edge.
  - When count==ITER-1 at the edge, go to XFER. RUN therefore lasts exactly ITER cycles.
- XFER: div_signal=F_OUT for one cycle. The divider loads its output register at this edge. Go to CAPT.
- CAPT: div_signal=000000. At the edge, hi<=div_result[63:32] and lo<=div_result[31:0]. Go to IDLE.
- Timing (DIVU accepted at edge E0):
  - stall rises after E0 and falls after E0+ITER+2.
  - HI/LO are valid from E0+ITER+2.
  - Total latency is ITER+2 cycles, i.e. 35 at the default.
- While stall=1:
  - All req are ignored, including DIVU, MTHI and MTLO. EX holds the instruction and re-presents it.
  - div_a and div_b remain stable.
- MFHI/MFLO:
  - rd_data reflects the current hi/lo combinationally in any state.
  - EX must not consume rd_data while stall=1.
- Same-cycle MTHI and a DIVU completion cannot occur, because requests are ignored in CAPT.
- Divide by zero:
  - The divide runs normally. The divider yields quotient 0xFFFFFFFF and remainder equal to the dividend, and these are captured unchanged.
  - div_zero is set and holds until the next accepted DIVU.
- div_signal is only ever 000000, F_DIVU or F_OUT; it never glitches between states (registered state decode).

Test Plan:
- Reset, then release; DIVU opA=100, opB=7 -> div_signal=011011 for exactly 33 cycles, then 111111 for 1 cycle, then 000000; stall high for 35 cycles; then hi=2, lo=14, div_zero=0.
- DIVU opA=0xFFFFFFFF, opB=1 -> lo=0xFFFFFFFF, hi=0; then DIVU opA=5, opB=9 -> lo=0, hi=5.
- DIVU opA=0x1234, opB=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1; next DIVU 10/3 clears div_zero; result hi=1, lo=3.
- MTHI opA=0xA5A5A5A5, then MTLO opA=0x5A5A5A5A -> MFHI rd_data=0xA5A5A5A5, MFLO rd_data=0x5A5A5A5A; stall never asserts.
- During a divide, present MTLO 0xDEAD and DIVU 1/1 at cycle 10 -> both ignored; div_a/div_b unchanged; final lo equals the original quotient.
- Assert reset at cycle 20 of a divide -> immediately state IDLE, stall=0, hi=lo=0, div_signal=000000, div_reset=1; after release, a new DIVU 9/2 completes with hi=1, lo=4.
